fp_mul_pack: RTL
================

# fp_mul_pack

Downstream result stage for the bfloat16 multiplier. It accepts the multiplier's unpacked sign/exponent/fraction/overflow outputs together with the two original packed operands. It resolves IEEE special cases (NaN, infinity, zero, subnormal flush), packs the final 16-bit bfloat16 word, and buffers it in a small FIFO with valid/ready handshakes on both sides. It also keeps sticky overflow and invalid exception flags for software readback.

## Interface
Parameters:
- DEPTH, 2: result FIFO entries; must be a power of two and at least 2.
- QNAN, 16'h7FC0: canonical quiet-NaN encoding emitted for every NaN result.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an operand pair plus its multiplier result.
- in_ready  out  1  stage can accept; equals !full, with no combinational path from out_ready.
- op1_raw  in  16  packed operand 1 (sign[15], exp[14:7], frac[6:0]).
- op2_raw  in  16  packed operand 2.
- mul_sign  in  1  multiplier result sign.
- mul_exp  in  8  multiplier result exponent (already forced to 8'hFF on overflow).
- mul_frac  in  7  multiplier result fraction.
- mul_overflow  in  1  multiplier exponent overflow.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  16  packed bfloat16 result at the FIFO head.
- out_exc  out  2  per-entry exception bits {invalid, overflow} travelling with out_data.
- flag_overflow  out  1  sticky overflow flag.
- flag_invalid  out  1  sticky invalid flag.
- flag_clr  in  1  clears both sticky flags.

## Operation
- Operand classification, per operand: exp==FF and frac!=0 is NaN; exp==FF and frac==0 is Inf; exp==00 is Zero (subnormals flush to zero); everything else is Normal.
- Result selection, in priority order, with s = op1[15]^op2[15]:
  1. Either operand NaN -> QNAN, invalid=1.
  2. Inf × Zero (either order) -> QNAN, invalid=1.
  3. Either operand Inf -> {s, 8'hFF, 7'h0}.
  4. Either operand Zero -> {s, 15'h0} (signed zero).
  5. mul_overflow -> {s, 8'hFF, 7'h0}, overflow=1.
  6. Otherwise -> {mul_sign, mul_exp, mul_frac}.
- Push happens when in_valid && in_ready. The packed word and the {invalid, overflow} bits are written at wptr.
- Pop happens when out_valid && out_ready. rptr advances.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked by a count register of log2(DEPTH)+1 bits (0..DEPTH).
- Full: count==DEPTH gives in_ready=0; in_valid is ignored.
- Empty: count==0 gives out_valid=0; out_data is held at its last value and is not checked.
- Push and pop in the same cycle: both occur and count is unchanged. This is legal at any non-empty occupancy. When full, no push can occur.
- Sticky flags: set on a push whose entry has the corresponding exc bit. flag_clr clears them. If a set and a clear land in the same cycle, the set wins.
- The stage never drops or reorders results; ordering is strictly FIFO.

## Timing
- Reset (rst_n low, asynchronous):
  - count, wptr, rptr, out_valid, out_data, out_exc, flag_overflow, flag_invalid all go to 0.
  - in_ready=1 while and after reset.
- Latency: an entry pushed at edge N is visible on out_valid/out_data immediately after edge N. This is one cycle from input acceptance, including when the FIFO was empty.
- Throughput: 1 result per cycle when out_ready is held high.
- in_ready depends only on registered count.
- out_data and out_exc are driven from FIFO storage selected by registered rptr, with no input-to-output combinational path.
- Reset mid-transfer discards all buffered entries and flags. The first push after rst_n deasserts is accepted normally.

## Test plan
- Normal path: op1=3F80, op2=4000, mul={0,80,00}, out_ready=1 -> out_data=4000 one cycle later; out_exc=00; flags stay 0.
- Special cases:
  - op1=7F80 × op2=0000 -> 7FC0 with out_exc=10 and flag_invalid=1.
  - op1=FF80 × op2=3F80 -> FF80.
  - op1=8000 × op2=4000 -> 8000.
  - op1=0001 (subnormal) × 3F80 -> 0000.
- Overflow: op1=7F00, op2=7F00, mul_overflow=1, mul_exp=FF -> 7F80, out_exc=01, flag_overflow=1. Pulsing flag_clr clears it. A simultaneous new overflow push with flag_clr leaves the flag at 1.
- Backpressure: out_ready=0, push 3 distinct values with DEPTH=2 -> in_ready drops after 2 pushes and the third is held upstream. With out_ready=1, outputs appear in push order, and in_ready returns to 1 after the first pop.
- Full-rate streaming: 16 back-to-back pushes with out_ready=1 -> 16 outputs in order with no bubbles, pointer wrap verified, and count never exceeds 1.
- Reset with 2 entries buffered and sticky flags set -> out_valid=0, flags=0, and in_ready=1 immediately. The next push yields the correct single output.

Source files
------------

// File: rtl/fp_mul_pack_if.sv
// fp_mul_pack_if: handshake/data bundle between the bfloat16 multiplier, the
// result pack stage and its downstream consumer.
//   in_valid/in_ready : upstream handshake carrying op1_raw/op2_raw and the
//                       unpacked multiplier result (mul_sign/exp/frac/overflow)
//   out_valid/out_ready: downstream handshake carrying out_data/out_exc
// slave  : view used by the pack stage.
// master : view used by the upstream/downstream environment.
interface fp_mul_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op1_raw;
  logic [15:0] op2_raw;
  logic        mul_sign;
  logic [7:0]  mul_exp;
  logic [6:0]  mul_frac;
  logic        mul_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_exc;

  modport slave (
    input  in_valid, op1_raw, op2_raw, mul_sign, mul_exp, mul_frac,
           mul_overflow, out_ready,
    output in_ready, out_valid, out_data, out_exc
  );

  modport master (
    output in_valid, op1_raw, op2_raw, mul_sign, mul_exp, mul_frac,
           mul_overflow, out_ready,
    input  in_ready, out_valid, out_data, out_exc
  );
endinterface

// File: rtl/fp_mul_pack.sv
// fp_mul_pack: bfloat16 multiplier result stage. Resolves NaN/Inf/Zero special
// cases from the original operands, packs the 16-bit result and buffers it,
// together with its {invalid, overflow} bits, in a DEPTH-entry FIFO.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : input/output valid-ready handshakes and data
//   flag_clr        : clears the sticky exception flags (a same-cycle set wins)
//   flag_overflow   : sticky overflow flag
//   flag_invalid    : sticky invalid flag
module fp_mul_pack #(
  parameter int unsigned DEPTH = 2,
  parameter logic [15:0] QNAN  = 16'h7FC0
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_mul_pack_if.slave       bus,
  input  logic               flag_clr,
  output logic               flag_overflow,
  output logic               flag_invalid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    CL_NORM,
    CL_ZERO,
    CL_INF,
    CL_NAN
  } cls_e;

  function automatic cls_e classify(input logic [15:0] v);
    if (v[14:7] == 8'hFF) return (v[6:0] != 7'h0) ? CL_NAN : CL_INF;
    if (v[14:7] == 8'h00) return CL_ZERO;   // subnormals flush to zero
    return CL_NORM;
  endfunction

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_data [DEPTH];
  logic [1:0]    r_exc  [DEPTH];
  logic          r_flag_ovf;
  logic          r_flag_inv;

  cls_e          w_c1;
  cls_e          w_c2;
  logic          w_sign;
  logic [15:0]   w_word;
  logic          w_inv;
  logic          w_ovf;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;

  // Special-case resolution in priority order.
  always_comb begin
    w_c1   = classify(bus.op1_raw);
    w_c2   = classify(bus.op2_raw);
    w_sign = bus.op1_raw[15] ^ bus.op2_raw[15];
    w_word = {bus.mul_sign, bus.mul_exp, bus.mul_frac};
    w_inv  = 1'b0;
    w_ovf  = 1'b0;
    if (w_c1 == CL_NAN || w_c2 == CL_NAN) begin
      w_word = QNAN;
      w_inv  = 1'b1;
    end else if ((w_c1 == CL_INF && w_c2 == CL_ZERO) ||
                 (w_c1 == CL_ZERO && w_c2 == CL_INF)) begin
      w_word = QNAN;
      w_inv  = 1'b1;
    end else if (w_c1 == CL_INF || w_c2 == CL_INF) begin
      w_word = {w_sign, 8'hFF, 7'h0};
    end else if (w_c1 == CL_ZERO || w_c2 == CL_ZERO) begin
      w_word = {w_sign, 15'h0};
    end else if (bus.mul_overflow) begin
      w_word = {w_sign, 8'hFF, 7'h0};
      w_ovf  = 1'b1;
    end
  end

  // Handshake status comes only from the registered count.
  assign w_in_ready  = (r_count != CNT_FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_flag_ovf <= 1'b0;
      r_flag_inv <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_exc[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= w_word;
        r_exc[r_wptr]  <= {w_inv, w_ovf};
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set has priority over a simultaneous clear.
      r_flag_ovf <= (r_flag_ovf & ~flag_clr) | (w_push & w_ovf);
      r_flag_inv <= (r_flag_inv & ~flag_clr) | (w_push & w_inv);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_data[r_rptr];
  assign bus.out_exc   = r_exc[r_rptr];
  assign flag_overflow = r_flag_ovf;
  assign flag_invalid  = r_flag_inv;

endmodule
